load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/load_extend.sv | 33 +++
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states, byte-enable helper.
// LSU_MISALIGNED_EN adds the split-access states REQ2/WAIT2.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_MISALIGNED_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, REQ2, WAIT2} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
`endif

    // Lanes for the access starting at byte 'offset'; 'upper' selects the lanes spilling into the next word.
    function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                                input logic [1:0] offset,
                                                input logic       upper);
        logic [7:0] mask;
        case (funct3)
            F3_B, F3_BU: mask = 8'b0000_0001;
            F3_H, F3_HU: mask = 8'b0000_0011;
            default:     mask = 8'b0000_1111;
        endcase
        mask = mask << offset;
        return upper ? mask[7:4] : mask[3:0];
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment: picks four bytes starting at 'offset' from the {hi, lo} word pair,
// then sign- or zero-extends according to funct3.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word_lo,
    input  logic [31:0] word_hi,
    output logic [31:0] result
);
    logic [63:0] pair;
    logic [31:0] aligned;
    logic [2:0]  sel;

    always_comb begin
        pair    = {word_hi, word_lo};
        aligned = '0;
        sel     = '0;
        for (int i = 0; i < 4; i++) begin
            sel = {1'b0, offset} + 3'(i);
            aligned[8*i +: 8] = pair[8*sel +: 8];
        end
        case (funct3)
            F3_B:    result = {{24{aligned[7]}}, aligned[7:0]};
            F3_H:    result = {{16{aligned[15]}}, aligned[15:0]};
            F3_BU:   result = {24'b0, aligned[7:0]};
            F3_HU:   result = {16'b0, aligned[15:0]};
            default: result = aligned;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit bridging a core request to a single-port word memory with gnt/rvalid handshake.
// Define LSU_MISALIGNED_EN to split misaligned accesses into two word accesses instead of faulting.
//
// state | meaning
// IDLE  | ready for a core operation
// REQ   | first (or only) memory request, held until mem_gnt
// WAIT  | load issued, waiting for mem_rvalid
// REQ2  | second word of a split access
// WAIT2 | second word of a split load, waiting for mem_rvalid
// DONE  | one-cycle completion/fault pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid,
    output logic        core_ready,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        core_done,
    output logic [31:0] ReadData,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
`ifdef LSU_MISALIGNED_EN
    localparam logic [30:0] WORD_LIMIT = 31'(DEPTH_WORDS);
`endif

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_lo_q;
    logic [31:0] rdata_hi;
    logic        fault_q;
    logic [1:0]  off;
    logic [31:0] load_result;

    logic f3_legal, misaligned, out_of_range, accept_fault;

    assign off = addr_q[1:0];

    always_comb begin
        case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
            default:                        f3_legal = 1'b0;
        endcase
        misaligned   = (((funct3 == F3_H) || (funct3 == F3_HU)) && ALUResult[0]) ||
                       ((funct3 == F3_W) && (ALUResult[1:0] != 2'b00));
        out_of_range = {1'b0, ALUResult} >= ADDR_LIMIT;
`ifdef LSU_MISALIGNED_EN
        // A split access must have its second word in range before anything is issued.
        accept_fault = !f3_legal || out_of_range ||
                       (misaligned && (({1'b0, ALUResult[31:2]} + 31'd1) >= WORD_LIMIT));
`else
        accept_fault = !f3_legal || out_of_range || misaligned;
`endif
    end

`ifdef LSU_MISALIGNED_EN
    logic        split_q;
    logic [31:0] rdata_hi_q;
    assign rdata_hi = rdata_hi_q;
`else
    assign rdata_hi = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        core_ready = 1'b0;
        core_done  = 1'b0;
        fault      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                core_ready = 1'b1;
                if (core_valid) state_nx = accept_fault ? DONE : REQ;
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q[31:2];
                mem_be    = byte_enables(f3_q, off, 1'b0);
                mem_wdata = wdata_q << {off, 3'b000};
                if (mem_gnt) begin
`ifdef LSU_MISALIGNED_EN
                    if (we_q) state_nx = split_q ? REQ2 : DONE;
                    else      state_nx = WAIT;
`else
                    state_nx = we_q ? DONE : WAIT;
`endif
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_EN
                    state_nx = split_q ? REQ2 : DONE;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef LSU_MISALIGNED_EN
            REQ2: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q[31:2] + 30'd1;
                mem_be    = byte_enables(f3_q, off, 1'b1);
                mem_wdata = wdata_q >> (6'd32 - {1'b0, off, 3'b000});
                if (mem_gnt) state_nx = we_q ? DONE : WAIT2;
            end
            WAIT2: begin
                if (mem_rvalid) state_nx = DONE;
            end
`endif
            DONE: begin
                core_done = 1'b1;
                fault     = fault_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fault_q    <= 1'b0;
            rdata_lo_q <= '0;
`ifdef LSU_MISALIGNED_EN
            split_q    <= 1'b0;
            rdata_hi_q <= '0;
`endif
        end else begin
            if (state == IDLE && core_valid) begin
                we_q    <= MemWrite;
                f3_q    <= funct3;
                addr_q  <= ALUResult;
                wdata_q <= WriteData;
                fault_q <= accept_fault;
`ifdef LSU_MISALIGNED_EN
                split_q <= misaligned;
`endif
            end
            if (state == WAIT && mem_rvalid) rdata_lo_q <= mem_rdata;
`ifdef LSU_MISALIGNED_EN
            if (state == WAIT2 && mem_rvalid) rdata_hi_q <= mem_rdata;
`endif
        end
    end

    load_extend u_load_extend (
        .funct3  (f3_q),
        .offset  (off),
        .word_lo (rdata_lo_q),
        .word_hi (rdata_hi),
        .result  (load_result)
    );

    assign ReadData = (state == DONE && !fault_q && !we_q) ? load_result : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table through a small memory responder,
// plus hand sequences for reset, early rvalid and abandoned transfers.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_valid;
    logic        core_ready;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        core_done;
    logic [31:0] ReadData;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.DEPTH_WORDS(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .core_done  (core_done),
        .ReadData   (ReadData),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          gd;
        logic        flt;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [29:0] maddr;
        logic [31:0] wdm;
        int          lat;
        int          nreq;
        int          reqcyc;
    } vec_t;

    vec_t vecs[$];

    logic        r_fault;
    logic [31:0] r_rd;
    logic [3:0]  r_be;
    logic [29:0] r_maddr;
    logic [31:0] r_wd;
    int          r_lat, r_nreq, r_reqcyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(string n, logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                int gd, logic flt, logic [31:0] rd, logic [3:0] be, logic [29:0] ma,
                                logic [31:0] wdm, int lat, int nreq, int rc);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.gd = gd; v.flt = flt;
        v.rd = rd; v.be = be; v.maddr = ma; v.wdm = wdm; v.lat = lat; v.nreq = nreq; v.reqcyc = rc;
        return v;
    endfunction

    function automatic vec_t mk_flt(string n, logic we, logic [2:0] f3, logic [31:0] a);
        return mk(n, we, f3, a, 32'h0, 0, 1'b1, 32'h0, 4'h0, 30'h0, 32'h0, 1, 0, 0);
    endfunction

    // Issue one operation at a negedge in IDLE; respond as a memory with gd wait cycles per request.
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd);
        int   waitcnt;
        logic seen;
        logic rv_pending;
        logic [9:0] rv_idx;
        waitcnt = 0; seen = 1'b0; rv_pending = 1'b0; rv_idx = '0;
        r_be = '0; r_maddr = '0; r_wd = '0; r_nreq = 0; r_reqcyc = 0;
        @(negedge clk);
        core_valid = 1'b1; MemWrite = we; funct3 = f3; ALUResult = a; WriteData = wd;
        @(negedge clk);
        core_valid = 1'b0;
        r_lat = 1;
        while (!core_done && r_lat < 40) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_pending) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem[rv_idx];
                rv_pending = 1'b0;
            end
            if (mem_req) begin
                r_reqcyc++;
                if (!seen) begin
                    seen = 1'b1; r_be = mem_be; r_maddr = mem_addr; r_wd = mem_wdata;
                end
                if (waitcnt == gd) begin
                    mem_gnt = 1'b1;
                    waitcnt = 0;
                    r_nreq++;
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) mem[mem_addr[9:0]][8*i +: 8] = mem_wdata[8*i +: 8];
                    end else begin
                        rv_pending = 1'b1;
                        rv_idx = mem_addr[9:0];
                    end
                end else begin
                    waitcnt++;
                end
            end
            @(negedge clk);
            r_lat++;
        end
        if (!core_done) check("done_timeout", {31'b0, core_done}, 32'h1);
        r_fault = fault;
        r_rd    = ReadData;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] m32;

        reset = 1'b1; core_valid = 1'b0; MemWrite = 1'b0; funct3 = '0; ALUResult = '0;
        WriteData = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h040] = 32'h11223344;
        mem[10'h041] = 32'h55667788;
        mem[10'h008] = 32'h80010000;
        mem[10'h009] = 32'h000000C3;
        mem[10'h3FF] = 32'hCAFEF00D;

        vecs.push_back(mk("sw_0x10",   1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 0, 32'h0,        4'hF, 30'h4,   32'hDEADBEEF, 2, 1, 1));
        vecs.push_back(mk("lw_0x10",   0, 3'b010, 32'h10,  32'h0,        2, 0, 32'hDEADBEEF, 4'hF, 30'h4,   32'h0,        5, 1, 3));
        vecs.push_back(mk("sb_0x13",   1, 3'b000, 32'h13,  32'h000000A5, 0, 0, 32'h0,        4'h8, 30'h4,   32'hA5000000, 2, 1, 1));
        vecs.push_back(mk("lbu_0x13",  0, 3'b100, 32'h13,  32'h0,        0, 0, 32'h000000A5, 4'h8, 30'h4,   32'h0,        3, 1, 1));
        vecs.push_back(mk("lb_0x13",   0, 3'b000, 32'h13,  32'h0,        0, 0, 32'hFFFFFFA5, 4'h8, 30'h4,   32'h0,        3, 1, 1));
        vecs.push_back(mk("lh_0x22",   0, 3'b001, 32'h22,  32'h0,        3, 0, 32'hFFFF8001, 4'hC, 30'h8,   32'h0,        6, 1, 4));
        vecs.push_back(mk("lhu_0x22",  0, 3'b101, 32'h22,  32'h0,        1, 0, 32'h00008001, 4'hC, 30'h8,   32'h0,        4, 1, 2));
        vecs.push_back(mk("sh_0x16",   1, 3'b001, 32'h16,  32'h1234ABCD, 0, 0, 32'h0,        4'hC, 30'h5,   32'hABCD0000, 2, 1, 1));
        vecs.push_back(mk("lh_0x16",   0, 3'b001, 32'h16,  32'h0,        0, 0, 32'hFFFFABCD, 4'hC, 30'h5,   32'h0,        3, 1, 1));
        vecs.push_back(mk("lb_0x16",   0, 3'b000, 32'h16,  32'h0,        0, 0, 32'hFFFFFFCD, 4'h4, 30'h5,   32'h0,        3, 1, 1));
        vecs.push_back(mk("lw_last",   0, 3'b010, 32'hFFC, 32'h0,        0, 0, 32'hCAFEF00D, 4'hF, 30'h3FF, 32'h0,        3, 1, 1));
        vecs.push_back(mk_flt("lw_4096",    0, 3'b010, 32'h1000));
        vecs.push_back(mk_flt("illegal_f3", 0, 3'b011, 32'h20));
        vecs.push_back(mk_flt("sw_0xFFE",   1, 3'b010, 32'hFFE));
`ifdef LSU_MISALIGNED_EN
        vecs.push_back(mk("lw_0x102",  0, 3'b010, 32'h102, 32'h0,        0, 0, 32'h77881122, 4'hC, 30'h40,  32'h0,        5, 2, 2));
        vecs.push_back(mk("lh_0x23",   0, 3'b001, 32'h23,  32'h0,        0, 0, 32'hFFFFC380, 4'h8, 30'h8,   32'h0,        5, 2, 2));
        vecs.push_back(mk("sw_0x31",   1, 3'b010, 32'h31,  32'hAABBCCDD, 0, 0, 32'h0,        4'hE, 30'hC,   32'hBBCCDD00, 3, 2, 2));
        vecs.push_back(mk("lw_0x30",   0, 3'b010, 32'h30,  32'h0,        0, 0, 32'hBBCCDD00, 4'hF, 30'hC,   32'h0,        3, 1, 1));
`else
        vecs.push_back(mk_flt("lw_0x102", 0, 3'b010, 32'h102));
        vecs.push_back(mk_flt("lh_0x23",  0, 3'b001, 32'h23));
        vecs.push_back(mk_flt("sw_0x31",  1, 3'b010, 32'h31));
        vecs.push_back(mk("lw_0x30",   0, 3'b010, 32'h30,  32'h0,        0, 0, 32'h0,        4'hF, 30'hC,   32'h0,        3, 1, 1));
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_core_ready", {31'b0, core_ready}, 32'h1);
        check("rst_core_done",  {31'b0, core_done},  32'h0);
        check("rst_fault",      {31'b0, fault},      32'h0);
        check("rst_mem_req",    {31'b0, mem_req},    32'h0);
        check("rst_mem_we",     {31'b0, mem_we},     32'h0);
        check("rst_read_data",  ReadData,            32'h0);
        check("rst_mem_addr",   {2'b0, mem_addr},    32'h0);
        check("rst_mem_be",     {28'b0, mem_be},     32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            do_op(vecs[k].we, vecs[k].f3, vecs[k].addr, vecs[k].wd, vecs[k].gd);
            check({vecs[k].name, "_fault"},  {31'b0, r_fault},   {31'b0, vecs[k].flt});
            check({vecs[k].name, "_rdata"},  r_rd,               vecs[k].rd);
            check({vecs[k].name, "_lat"},    32'(r_lat),         32'(vecs[k].lat));
            check({vecs[k].name, "_nreq"},   32'(r_nreq),        32'(vecs[k].nreq));
            check({vecs[k].name, "_reqcyc"}, 32'(r_reqcyc),      32'(vecs[k].reqcyc));
            check({vecs[k].name, "_be"},     {28'b0, r_be},      {28'b0, vecs[k].be});
            check({vecs[k].name, "_addr"},   {2'b0, r_maddr},    {2'b0, vecs[k].maddr});
            if (vecs[k].we) begin
                for (int i = 0; i < 4; i++) m32[8*i +: 8] = {8{vecs[k].be[i]}};
                check({vecs[k].name, "_wdata"}, r_wd & m32, vecs[k].wdm);
            end
        end

        // rvalid together with gnt must be ignored; the real response comes later
        @(negedge clk);
        @(negedge clk);
        core_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h40; WriteData = '0;
        @(negedge clk);
        core_valid = 1'b0;
        check("early_rv_req", {31'b0, mem_req}, 32'h1);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("early_rv_mem_req_off", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        check("early_rv_not_done", {31'b0, core_done}, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h600D600D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("early_rv_done",  {31'b0, core_done}, 32'h1);
        check("early_rv_rdata", ReadData, 32'h600D600D);
        @(negedge clk);
        check("idle_rdata_zero", ReadData, 32'h0);
        check("idle_ready",      {31'b0, core_ready}, 32'h1);

        // reset in WAIT abandons the load; a late rvalid in IDLE does nothing
        core_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h10;
        @(negedge clk);
        core_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("wait_not_ready", {31'b0, core_ready}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_ready", {31'b0, core_ready}, 32'h1);
        check("rst_wait_req",   {31'b0, mem_req},    32'h0);
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rv_done",  {31'b0, core_done}, 32'h0);
        check("late_rv_ready", {31'b0, core_ready}, 32'h1);
        check("late_rv_rdata", ReadData, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
